// File: rtl/bolt_engine.sv
// rtl/bolt_engine.sv - four player and four invader bolt slots with motion, retire, kill and pixel hit test
// Slots 0-3 are player bolts (move up), slots 4-7 are invader bolts (move down).
module bolt_engine #(
  parameter int BOLT_W   = 2,
  parameter int BOLT_H   = 8,
  parameter int P_SPEED  = 4,
  parameter int I_SPEED  = 2,
  parameter int T_BORDER = 0,
  parameter int B_BORDER = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [3:0]  btpExs,
  input  logic [3:0]  btiExs,
  input  logic [10:0] btxLoc,
  input  logic [10:0] btyLoc,
  input  logic [3:0]  btpKil,
  input  logic [3:0]  btiKil,
  output logic [3:0]  btpReq,
  output logic [3:0]  btiReq,
  output logic [3:0]  btpAct,
  output logic [3:0]  btiAct,
  output logic [3:0]  btpDon,
  output logic [3:0]  btiDon
);

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} state_t;

  localparam logic [11:0] P_LIMIT = 12'(T_BORDER + P_SPEED);
  localparam logic [11:0] I_LIMIT = 12'(B_BORDER);
  localparam logic [11:0] I_STEP  = 12'(I_SPEED);
  localparam logic [10:0] P_STEP  = 11'(P_SPEED);
  localparam logic [11:0] X_SPAN  = 12'(BOLT_W);
  localparam logic [11:0] Y_SPAN  = 12'(BOLT_H);

  state_t      state_q [8];
  state_t      state_d [8];
  logic [10:0] x_q [8];
  logic [10:0] x_d [8];
  logic [10:0] y_q [8];
  logic [10:0] y_d [8];
  logic [7:0]  don_q, don_d;
  logic [7:0]  act, kil, grant, req;

  // Isolates the lowest set bit: only the lowest-index idle requested slot loads.
  function automatic logic [3:0] pick_lowest(input logic [3:0] r);
    return r & (~r + 4'd1);
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) act[i] = (state_q[i] == FLY);
    kil   = {btiKil, btpKil};
    grant = {pick_lowest(btiExs & ~act[7:4]), pick_lowest(btpExs & ~act[3:0])};
  end

  always_comb begin
    don_d = '0;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      if (state_q[i] == FLY) begin
        if (kil[i]) begin
          state_d[i] = IDLE;
        end else if (startOfFrame) begin
          if (i < 4) begin
            if ({1'b0, y_q[i]} < P_LIMIT) begin
              state_d[i] = IDLE;
              don_d[i]   = 1'b1;
            end else begin
              y_d[i] = y_q[i] - P_STEP;
            end
          end else begin
            if (({1'b0, y_q[i]} + I_STEP) > I_LIMIT) begin
              state_d[i] = IDLE;
              don_d[i]   = 1'b1;
            end else begin
              y_d[i] = 11'({1'b0, y_q[i]} + I_STEP);
            end
          end
        end
      end else if (grant[i]) begin
        state_d[i] = FLY;
        x_d[i]     = btxLoc;
        y_d[i]     = btyLoc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      don_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      don_q <= don_d;
    end
  end

  // Bounds are widened to 12 bits so a bolt near 2047 never wraps its window.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      req[i] = act[i]
        && ({1'b0, pixelX} >= {1'b0, x_q[i]}) && ({1'b0, pixelX} < ({1'b0, x_q[i]} + X_SPAN))
        && ({1'b0, pixelY} >= {1'b0, y_q[i]}) && ({1'b0, pixelY} < ({1'b0, y_q[i]} + Y_SPAN));
    end
  end

  assign btpAct = act[3:0];
  assign btiAct = act[7:4];
  assign btpReq = req[3:0];
  assign btiReq = req[7:4];
  assign btpDon = don_q[3:0];
  assign btiDon = don_q[7:4];

endmodule

// File: tb/tb_bolt_engine.sv
// tb/tb_bolt_engine.sv - scoreboard-driven bench for bolt_engine
module tb_bolt_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0, btxLoc = '0, btyLoc = '0;
  logic [3:0]  btpExs = '0, btiExs = '0, btpKil = '0, btiKil = '0;
  logic [3:0]  btpReq, btiReq, btpAct, btiAct, btpDon, btiDon;

  typedef struct {
    string      n;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  bolt_engine dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .btpExs(btpExs), .btiExs(btiExs), .btxLoc(btxLoc), .btyLoc(btyLoc),
    .btpKil(btpKil), .btiKil(btiKil),
    .btpReq(btpReq), .btiReq(btiReq), .btpAct(btpAct), .btiAct(btiAct),
    .btpDon(btpDon), .btiDon(btiDon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    startOfFrame = 1'b0;
    btpExs = '0; btiExs = '0; btpKil = '0; btiKil = '0;
  endtask

  task automatic test_reset();
    pixelX = '0; pixelY = '0;
    repeat (2) @(posedge clk);
    #2;
    sb.push_back('{"rst_pact", 4'b0000}); sb.push_back('{"rst_iact", 4'b0000});
    sb.push_back('{"rst_don", 4'b0000});  sb.push_back('{"rst_req", 4'b0000});
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
    e = sb.pop_front(); n_vec++; if ((btpDon | btiDon) !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpDon | btiDon, e.v); end
    e = sb.pop_front(); n_vec++; if ((btpReq | btiReq) !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq | btiReq, e.v); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_player_motion();
    int px[6] = '{100, 101, 99, 102, 100, 100};
    int py[6] = '{368, 375, 368, 368, 367, 376};
    logic [3:0] pr[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    btpExs = 4'b0001; btxLoc = 11'd100; btyLoc = 11'd380;
    sb.push_back('{"spawn_act", 4'b0001});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
    repeat (3) begin startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick(); end
    for (int k = 0; k < 6; k++) begin
      pixelX = 11'(px[k]); pixelY = 11'(py[k]);
      sb.push_back('{$sformatf("preq_%0d_%0d", px[k], py[k]), pr[k]});
      #1;
      e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    end
  endtask

  task automatic test_player_retire();
    btpKil = 4'b0001; sb.push_back('{"kill_no_don", 4'b0000});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btpDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpDon, e.v); end
    btpExs = 4'b0001; btxLoc = 11'd20; btyLoc = 11'd3;
    tick(); clear_inputs();
    startOfFrame = 1'b1;
    sb.push_back('{"pret_act", 4'b0000}); sb.push_back('{"pret_don", 4'b0001});
    sb.push_back('{"pret_req", 4'b0000}); sb.push_back('{"pret_don_end", 4'b0000});
    tick(); clear_inputs();
    pixelX = 11'd20; pixelY = 11'd3; #1;
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btpDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpDon, e.v); end
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    tick();
    e = sb.pop_front(); n_vec++; if (btpDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpDon, e.v); end
  endtask

  task automatic test_invader_retire();
    btiExs = 4'b0001; btxLoc = 11'd50; btyLoc = 11'd397;
    tick(); clear_inputs();
    startOfFrame = 1'b1;
    sb.push_back('{"iret_req399", 4'b0001}); sb.push_back('{"iret_req398", 4'b0000});
    tick(); clear_inputs();
    pixelX = 11'd50; pixelY = 11'd399; #1;
    e = sb.pop_front(); n_vec++; if (btiReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiReq, e.v); end
    pixelY = 11'd398; #1;
    e = sb.pop_front(); n_vec++; if (btiReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiReq, e.v); end
    startOfFrame = 1'b1;
    sb.push_back('{"iret_act", 4'b0000}); sb.push_back('{"iret_don", 4'b0001}); sb.push_back('{"iret_don_end", 4'b0000});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btiDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiDon, e.v); end
    tick();
    e = sb.pop_front(); n_vec++; if (btiDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiDon, e.v); end
  endtask

  task automatic test_kill();
    btiExs = 4'b0100; btxLoc = 11'd10; btyLoc = 11'd200;
    sb.push_back('{"kill_pre_act", 4'b0100});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
    btiKil = 4'b0100; startOfFrame = 1'b1;
    sb.push_back('{"kill_act", 4'b0000}); sb.push_back('{"kill_don", 4'b0000}); sb.push_back('{"kill_don2", 4'b0000});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btiDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiDon, e.v); end
    tick();
    e = sb.pop_front(); n_vec++; if (btiDon !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiDon, e.v); end
  endtask

  task automatic test_multi_spawn();
    btpExs = 4'b0010; btxLoc = 11'd300; btyLoc = 11'd100;
    tick(); clear_inputs();
    btpExs = 4'b0110; btxLoc = 11'd500; btyLoc = 11'd50;
    sb.push_back('{"multi_act", 4'b0110}); sb.push_back('{"multi_s1", 4'b0010}); sb.push_back('{"multi_s2", 4'b0100});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
    pixelX = 11'd300; pixelY = 11'd100; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    pixelX = 11'd500; pixelY = 11'd50; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    btpExs = 4'b0010; btxLoc = 11'd600; btyLoc = 11'd60;
    sb.push_back('{"refly_new", 4'b0000}); sb.push_back('{"refly_old", 4'b0010});
    tick(); clear_inputs();
    pixelX = 11'd600; pixelY = 11'd60; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    pixelX = 11'd300; pixelY = 11'd100; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    btiExs = 4'b1111; btxLoc = 11'd40; btyLoc = 11'd40;
    sb.push_back('{"all_bits_act", 4'b0001});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
  endtask

  task automatic test_spawn_sof();
    btpExs = 4'b1000; btxLoc = 11'd700; btyLoc = 11'd200; startOfFrame = 1'b1;
    sb.push_back('{"sof_new", 4'b1000}); sb.push_back('{"sof_s1_96", 4'b0010}); sb.push_back('{"sof_s1_95", 4'b0000});
    sb.push_back('{"sof_i41", 4'b0000}); sb.push_back('{"sof_i42", 4'b0001});
    tick(); clear_inputs();
    pixelX = 11'd700; pixelY = 11'd200; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    pixelX = 11'd300; pixelY = 11'd96; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    pixelY = 11'd95; #1;
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    pixelX = 11'd40; pixelY = 11'd41; #1;
    e = sb.pop_front(); n_vec++; if (btiReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiReq, e.v); end
    pixelY = 11'd42; #1;
    e = sb.pop_front(); n_vec++; if (btiReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiReq, e.v); end
  endtask

  task automatic test_back_to_back_reset();
    logic [3:0] seen_don;
    logic [3:0] ispawn[4] = '{4'b0000, 4'b0010, 4'b0100, 4'b1000};
    btxLoc = 11'd800; btyLoc = 11'd300;
    for (int k = 0; k < 4; k++) begin
      btpExs = (k == 0) ? 4'b0001 : 4'b0000;
      btiExs = ispawn[k];
      tick(); clear_inputs();
    end
    pixelX = 11'd800; pixelY = 11'd300;
    sb.push_back('{"all_pact", 4'b1111}); sb.push_back('{"all_iact", 4'b1111});
    sb.push_back('{"all_preq", 4'b0001}); sb.push_back('{"all_ireq", 4'b1110});
    #1;
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btiAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiAct, e.v); end
    e = sb.pop_front(); n_vec++; if (btpReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq, e.v); end
    e = sb.pop_front(); n_vec++; if (btiReq !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btiReq, e.v); end
    #1 reset = 1'b1;
    #1;
    sb.push_back('{"mid_act", 4'b0000}); sb.push_back('{"mid_req", 4'b0000}); sb.push_back('{"mid_don", 4'b0000});
    e = sb.pop_front(); n_vec++; if ((btpAct | btiAct) !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct | btiAct, e.v); end
    e = sb.pop_front(); n_vec++; if ((btpReq | btiReq) !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpReq | btiReq, e.v); end
    e = sb.pop_front(); n_vec++; if ((btpDon | btiDon) !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpDon | btiDon, e.v); end
    startOfFrame = 1'b1;
    tick();
    reset = 1'b0;
    seen_don = '0;
    sb.push_back('{"post_rst_don", 4'b0000});
    for (int k = 0; k < 6; k++) begin
      startOfFrame = k[0];
      tick();
      seen_don = seen_don | btpDon | btiDon;
    end
    clear_inputs();
    e = sb.pop_front(); n_vec++; if (seen_don !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, seen_don, e.v); end
    btpExs = 4'b0001; btxLoc = 11'd5; btyLoc = 11'd5;
    sb.push_back('{"post_rst_spawn", 4'b0001});
    tick(); clear_inputs();
    e = sb.pop_front(); n_vec++; if (btpAct !== e.v) begin n_bad++; $display("FAIL %s got %b want %b", e.n, btpAct, e.v); end
  endtask

  initial begin
    test_reset();
    test_player_motion();
    test_player_retire();
    test_invader_retire();
    test_kill();
    test_multi_spawn();
    test_spawn_sof();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
